// File: rtl/chess_pkg.sv
// Shared definitions for the timed chess game: side encoding, scheduler states,
// and the piece codes exchanged with the layout matrix.
package chess_pkg;

  localparam logic WHITE_PLAYER = 1'b1;
  localparam logic BLACK_PLAYER = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_PAUSE  = 3'd2,
    ST_SWITCH = 3'd3,
    ST_OVER   = 3'd4
  } game_state_e;

  typedef enum logic [2:0] {
    PC_EMPTY  = 3'd0,
    PC_PAWN   = 3'd1,
    PC_KNIGHT = 3'd2,
    PC_BISHOP = 3'd3,
    PC_ROOK   = 3'd4,
    PC_QUEEN  = 3'd5,
    PC_KING   = 3'd6
  } piece_e;

  function automatic logic other_player(input logic p);
    return (p == WHITE_PLAYER) ? BLACK_PLAYER : WHITE_PLAYER;
  endfunction

endpackage

// File: rtl/chess_player_clock.sv
// One player's remaining-seconds counter: load, decrement that stops at zero,
// and a saturating add used for the per-move time bonus.
module chess_player_clock #(
  parameter int TIME_WIDTH    = 12,
  parameter int RESET_SECONDS = 300
) (
  input  logic                  OutClock,
  input  logic                  resetApp,
  input  logic                  load,
  input  logic [TIME_WIDTH-1:0] load_val,
  input  logic                  dec,
  input  logic                  add_en,
  input  logic [TIME_WIDTH-1:0] add_val,
  output logic [TIME_WIDTH-1:0] secs,
  output logic                  zero
);

  logic [TIME_WIDTH-1:0] secs_q, secs_d;
  logic [TIME_WIDTH-1:0] dec_val;
  logic [TIME_WIDTH:0]   sum;

  // Decrement is applied before the bonus so a move on a wrap cycle is charged first.
  always_comb begin
    dec_val = (dec && (secs_q != '0)) ? secs_q - TIME_WIDTH'(1) : secs_q;
    sum     = {1'b0, dec_val} + {1'b0, add_val};
    secs_d  = dec_val;
    if (add_en) secs_d = sum[TIME_WIDTH] ? '1 : sum[TIME_WIDTH-1:0];
    if (load)   secs_d = load_val;
  end

  always_ff @(posedge OutClock or posedge resetApp) begin
    if (resetApp) secs_q <= TIME_WIDTH'(RESET_SECONDS);
    else          secs_q <= secs_d;
  end

  assign secs = secs_q;
  assign zero = (secs_q == '0);

endmodule

// File: rtl/chess_turn_scheduler.sv
// Turn/time controller: whose move, two countdown clocks, and the layout lock gate.
// Optional per-move time bonus enabled by defining CHESS_INCREMENT_EN.
//
//   state  | meaning
//   IDLE   | waiting for StartGame rising edge, clocks held at start value
//   RUN    | side to move is on the clock, layout may commit
//   PAUSE  | everything frozen while PauseSwitch is high
//   SWITCH | one-cycle lockout after a move, Player already toggled
//   OVER   | game ended (capture or flag fall), sticky until reset
module chess_turn_scheduler
  import chess_pkg::*;
#(
  parameter int TICKS_PER_SEC  = 10,
  parameter int START_SECONDS  = 300,
  parameter int TIME_WIDTH     = 12,
  parameter int INCREMENT_SECS = 2
) (
  input  logic                  OutClock,
  input  logic                  resetApp,
  input  logic                  StartGame,
  input  logic                  PauseSwitch,
  input  logic                  MoveDone,
  input  logic                  KingCaptured,
  output logic                  Player,
  output logic                  LockEnable,
  output logic [TIME_WIDTH-1:0] WhiteSeconds,
  output logic [TIME_WIDTH-1:0] BlackSeconds,
  output logic [2:0]            GameState,
  output logic                  Winner,
  output logic                  Timeout
);

  localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

`ifdef CHESS_INCREMENT_EN
  localparam logic INC_ON = 1'b1;
`else
  localparam logic INC_ON = 1'b0;
`endif

  game_state_e       state_q, state_d;
  logic              player_q, player_d;
  logic              lock_q, lock_d;
  logic              winner_q, winner_d;
  logic              timeout_q, timeout_d;
  logic              start_q, start_d;
  logic [TICK_W-1:0] tick_q, tick_d;

  logic wrap, act_zero, move_sw;
  logic load_clk, w_dec, b_dec, w_add, b_add;
  logic w_zero, b_zero;

  assign wrap     = (tick_q == TICK_W'(TICKS_PER_SEC - 1));
  assign act_zero = (player_q == WHITE_PLAYER) ? w_zero : b_zero;

  always_comb begin
    state_d   = state_q;
    player_d  = player_q;
    lock_d    = lock_q;
    winner_d  = winner_q;
    timeout_d = timeout_q;
    tick_d    = tick_q;
    start_d   = StartGame;
    load_clk  = 1'b0;
    move_sw   = 1'b0;
    w_dec     = 1'b0;
    b_dec     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        load_clk = 1'b1;
        if (StartGame && !start_q) begin
          state_d = ST_RUN;
          lock_d  = 1'b1;
        end
      end
      ST_RUN: begin
        // Priority: king capture, then flag fall, then move, then pause.
        if (MoveDone && KingCaptured) begin
          state_d   = ST_OVER;
          winner_d  = player_q;
          timeout_d = 1'b0;
          lock_d    = 1'b0;
        end else if (wrap && act_zero) begin
          state_d   = ST_OVER;
          winner_d  = other_player(player_q);
          timeout_d = 1'b1;
          lock_d    = 1'b0;
        end else if (MoveDone) begin
          state_d  = ST_SWITCH;
          lock_d   = 1'b0;
          player_d = other_player(player_q);
          tick_d   = '0;
          move_sw  = 1'b1;
          w_dec    = wrap && (player_q == WHITE_PLAYER);
          b_dec    = wrap && (player_q == BLACK_PLAYER);
        end else if (PauseSwitch) begin
          state_d = ST_PAUSE;
          lock_d  = 1'b0;
        end else begin
          tick_d = wrap ? '0 : tick_q + TICK_W'(1);
          w_dec  = wrap && (player_q == WHITE_PLAYER);
          b_dec  = wrap && (player_q == BLACK_PLAYER);
        end
      end
      ST_PAUSE: begin
        if (!PauseSwitch) begin
          state_d = ST_RUN;
          lock_d  = 1'b1;
        end
      end
      ST_SWITCH: begin
        state_d = ST_RUN;
        lock_d  = 1'b1;
      end
      ST_OVER: begin
      end
      default: begin
        state_d = ST_IDLE;
        lock_d  = 1'b0;
      end
    endcase
  end

  assign w_add = INC_ON && move_sw && (player_q == WHITE_PLAYER);
  assign b_add = INC_ON && move_sw && (player_q == BLACK_PLAYER);

  always_ff @(posedge OutClock or posedge resetApp) begin
    if (resetApp) begin
      state_q   <= ST_IDLE;
      player_q  <= WHITE_PLAYER;
      lock_q    <= 1'b0;
      winner_q  <= 1'b0;
      timeout_q <= 1'b0;
      start_q   <= 1'b0;
      tick_q    <= '0;
    end else begin
      state_q   <= state_d;
      player_q  <= player_d;
      lock_q    <= lock_d;
      winner_q  <= winner_d;
      timeout_q <= timeout_d;
      start_q   <= start_d;
      tick_q    <= tick_d;
    end
  end

  chess_player_clock #(
    .TIME_WIDTH    (TIME_WIDTH),
    .RESET_SECONDS (START_SECONDS)
  ) u_white_clock (
    .OutClock (OutClock),
    .resetApp (resetApp),
    .load     (load_clk),
    .load_val (TIME_WIDTH'(START_SECONDS)),
    .dec      (w_dec),
    .add_en   (w_add),
    .add_val  (TIME_WIDTH'(INCREMENT_SECS)),
    .secs     (WhiteSeconds),
    .zero     (w_zero)
  );

  chess_player_clock #(
    .TIME_WIDTH    (TIME_WIDTH),
    .RESET_SECONDS (START_SECONDS)
  ) u_black_clock (
    .OutClock (OutClock),
    .resetApp (resetApp),
    .load     (load_clk),
    .load_val (TIME_WIDTH'(START_SECONDS)),
    .dec      (b_dec),
    .add_en   (b_add),
    .add_val  (TIME_WIDTH'(INCREMENT_SECS)),
    .secs     (BlackSeconds),
    .zero     (b_zero)
  );

  assign GameState  = state_q;
  assign Player     = player_q;
  assign LockEnable = lock_q;
  assign Winner     = winner_q;
  assign Timeout    = timeout_q;

endmodule
